duty_jog_ctrl: RTL and testbench
================================

Name: duty_jog_ctrl

Overview:
- Front-end stage that turns the four raw push-buttons into 6-bit X/Y duty positions, plus single-cycle step strobes for the downstream recorder/playback RAM.
- Synchronises and debounces each button, edge-detects it and auto-repeats while it is held.
- Emits one clean pulse per step, so the recorder advances its store address exactly once per step instead of once per clock while a button is held.

Parameters:
DB_CYCLES, 50000, consecutive stable synchronised samples required before the debounced level changes
REPEAT_DELAY, 25000000, cycles a button must stay held after its first step before auto-repeat starts
REPEAT_PERIOD, 5000000, cycles between auto-repeat steps once repeat is active
DUTY_INIT, 32, value loaded into Duty_X and Duty_Y on reset (0..63)
DUTY_MAX, 63, upper saturation limit for both axes (lower limit fixed at 0)

Ports:
sysclk  in  1  system clock, all logic on rising edge
Reset_Sw  in  1  synchronous, active-high reset
Bt_Up_Raw  in  1  raw asynchronous Up button, active high
Bt_Down_Raw  in  1  raw asynchronous Down button, active high
Bt_Left_Raw  in  1  raw asynchronous Left button, active high
Bt_Right_Raw  in  1  raw asynchronous Right button, active high
Duty_X  out  6  registered X duty position
Duty_Y  out  6  registered Y duty position
Bt_Up  out  1  one-cycle step strobe, Up
Bt_Down  out  1  one-cycle step strobe, Down
Bt_Left  out  1  one-cycle step strobe, Left
Bt_Right  out  1  one-cycle step strobe, Right

Behaviour:
- Clocking and reset:
  - One clock (sysclk). Reset is synchronous and active-high on Reset_Sw.
  - Reset has priority over all other logic.
- Reset values:
  - Duty_X = Duty_Y = DUTY_INIT.
  - All strobes = 0.
  - Synchroniser flops, debounced levels, debounce counters and repeat counters = 0.
  - All four repeat FSMs go to IDLE.
- Synchroniser: each raw input passes through a 2-flop synchroniser.
- Debounce (per button):
  - Counter increments while the synchronised sample differs from the debounced level.
  - Counter clears to 0 on any sample that equals the debounced level.
  - When the counter reaches DB_CYCLES-1 with a still-differing sample, the debounced level toggles and the counter clears.
- Repeat FSM (per button), states IDLE, FIRST, REPEAT:
  - IDLE -> FIRST on debounced rising edge; issue one step.
  - FIRST: count REPEAT_DELAY cycles, then -> REPEAT and issue one step.
  - REPEAT: issue one step every REPEAT_PERIOD cycles.
  - FIRST or REPEAT -> IDLE the cycle after the debounced level falls; the counter clears and no step is issued.
- Step application:
  - Up: Duty_Y+1. Down: Duty_Y-1. Right: Duty_X+1. Left: Duty_X-1.
  - Results saturate at DUTY_MAX and at 0; no wrap-around.
  - Arithmetic is done at 7 bits before clamping.
- Strobes:
  - A strobe is registered and high for exactly one cycle per step.
  - The updated Duty value becomes visible in the same cycle as its strobe.
  - A strobe still fires when the step is saturated; the duty value does not change.
- Latency: raw rising edge held stable -> first strobe high exactly DB_CYCLES+3 cycles later (2 sync + DB_CYCLES debounce + 1 output register).
- Simultaneous events:
  - Up and Down stepping in the same cycle: both strobes fire, Duty_Y unchanged. Left and Right likewise on Duty_X.
  - Steps on different axes in the same cycle are all applied.
- Bounce: glitches shorter than DB_CYCLES produce no debounced change and no strobe.
- Reset mid-operation:
  - Reset_Sw high during repeat aborts immediately; Duty values return to DUTY_INIT.
  - A button still held after reset release is treated as a new press: first strobe DB_CYCLES+3 cycles after reset deasserts.
- No strobe is produced on button release.

Test Plan:
- Reset behaviour. Params DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. Assert Reset_Sw for 2 cycles -> Duty_X=Duty_Y=32, all strobes 0.
- Single press:
  - Stimulus: Bt_Up_Raw high for 10 cycles.
  - Response: Bt_Up pulses once, 7 cycles after the rise; Duty_Y=33 in the same cycle; no pulse on release.
- Bounce rejection: Bt_Right_Raw toggles every 2 cycles for 20 cycles, then stays low -> no strobes, Duty_X=32.
- Auto-repeat:
  - Stimulus: hold Bt_Left_Raw for 60 cycles.
  - Response: pulses at +7, +27, +35, +43, +51, +59; Duty_X 32->26.
- Saturation and opposing buttons:
  - From Duty_Y=63, press Up -> Bt_Up pulses, Duty_Y stays 63.
  - Press Up and Down simultaneously -> both strobes fire in the same cycle, Duty_Y unchanged.
- Reset mid-repeat:
  - Stimulus: hold Bt_Down_Raw until Duty_Y=28, pulse Reset_Sw for 1 cycle, keep holding.
  - Response: Duty_Y=32; next Bt_Down pulse 7 cycles after reset release, Duty_Y=31.

Source files
------------

// File: rtl/duty_jog_ctrl.sv
// Button front end: sync, debounce and auto-repeat of four jog buttons,
// producing one-cycle step strobes and saturating 6-bit X/Y duty positions.
module duty_jog_ctrl #(
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int DUTY_INIT     = 32,
    parameter int DUTY_MAX      = 63
) (
    input  logic       sysclk,
    input  logic       Reset_Sw,
    input  logic       Bt_Up_Raw,
    input  logic       Bt_Down_Raw,
    input  logic       Bt_Left_Raw,
    input  logic       Bt_Right_Raw,
    output logic [5:0] Duty_X,
    output logic [5:0] Duty_Y,
    output logic       Bt_Up,
    output logic       Bt_Down,
    output logic       Bt_Left,
    output logic       Bt_Right
);

    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [RCW-1:0] DLY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PER_LAST = RCW'(REPEAT_PERIOD - 1);
    localparam logic [6:0]     MAX7     = 7'(DUTY_MAX);
    localparam logic [5:0]     INIT6    = 6'(DUTY_INIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_REPEAT
    } state_t;

    // Bit order everywhere: 0 Up, 1 Down, 2 Left, 3 Right.
    logic [3:0]     w_raw;
    logic [3:0]     r_sync1;
    logic [3:0]     r_sync2;
    logic [3:0]     r_db;
    logic [DBW-1:0] r_db_cnt [4];
    state_t         r_state [4];
    state_t         w_state_nx [4];
    logic [RCW-1:0] r_rep_cnt [4];
    logic [RCW-1:0] w_rep_cnt_nx [4];
    logic [3:0]     w_step;
    logic [3:0]     r_strobe;
    logic [5:0]     r_duty_x;
    logic [5:0]     r_duty_y;

    assign w_raw = {Bt_Right_Raw, Bt_Left_Raw, Bt_Down_Raw, Bt_Up_Raw};

    always_ff @(posedge sysclk) begin
        if (Reset_Sw) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= ~r_db[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (Reset_Sw) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i]   <= S_IDLE;
                r_rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i]   <= w_state_nx[i];
                r_rep_cnt[i] <= w_rep_cnt_nx[i];
            end
        end
    end

    // A falling debounced level wins over a due repeat step.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_state_nx[i]   = r_state[i];
            w_rep_cnt_nx[i] = r_rep_cnt[i];
            w_step[i]       = 1'b0;
            unique case (r_state[i])
                S_IDLE: begin
                    if (r_db[i]) begin
                        w_state_nx[i]   = S_FIRST;
                        w_rep_cnt_nx[i] = '0;
                        w_step[i]       = 1'b1;
                    end
                end
                S_FIRST: begin
                    if (!r_db[i]) begin
                        w_state_nx[i]   = S_IDLE;
                        w_rep_cnt_nx[i] = '0;
                    end else if (r_rep_cnt[i] == DLY_LAST) begin
                        w_state_nx[i]   = S_REPEAT;
                        w_rep_cnt_nx[i] = '0;
                        w_step[i]       = 1'b1;
                    end else begin
                        w_rep_cnt_nx[i] = r_rep_cnt[i] + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!r_db[i]) begin
                        w_state_nx[i]   = S_IDLE;
                        w_rep_cnt_nx[i] = '0;
                    end else if (r_rep_cnt[i] == PER_LAST) begin
                        w_rep_cnt_nx[i] = '0;
                        w_step[i]       = 1'b1;
                    end else begin
                        w_rep_cnt_nx[i] = r_rep_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nx[i]   = S_IDLE;
                    w_rep_cnt_nx[i] = '0;
                end
            endcase
        end
    end

    // Decrement below zero wraps to bit 6 set, which is then clamped to 0.
    function automatic logic [5:0] f_apply(
        input logic [5:0] v,
        input logic       inc,
        input logic       dec
    );
        logic [6:0] s;
        s = {1'b0, v};
        if (inc && !dec) begin
            s = s + 7'd1;
            if (s > MAX7) s = MAX7;
        end else if (dec && !inc) begin
            s = s - 7'd1;
            if (s[6]) s = 7'd0;
        end
        return s[5:0];
    endfunction

    always_ff @(posedge sysclk) begin
        if (Reset_Sw) begin
            r_strobe <= '0;
            r_duty_x <= INIT6;
            r_duty_y <= INIT6;
        end else begin
            r_strobe <= w_step;
            r_duty_y <= f_apply(r_duty_y, w_step[0], w_step[1]);
            r_duty_x <= f_apply(r_duty_x, w_step[3], w_step[2]);
        end
    end

    assign Duty_X   = r_duty_x;
    assign Duty_Y   = r_duty_y;
    assign Bt_Up    = r_strobe[0];
    assign Bt_Down  = r_strobe[1];
    assign Bt_Left  = r_strobe[2];
    assign Bt_Right = r_strobe[3];

endmodule

// File: tb/tb_duty_jog_ctrl.sv
// Scoreboard bench for duty_jog_ctrl with small debounce/repeat parameters.
// Expected strobes carry their cycle number and duty values.
module tb_duty_jog_ctrl;

    logic       sysclk = 1'b0;
    logic       Reset_Sw = 1'b1;
    logic       up_raw = 1'b0;
    logic       dn_raw = 1'b0;
    logic       lf_raw = 1'b0;
    logic       rt_raw = 1'b0;
    logic [5:0] duty_x;
    logic [5:0] duty_y;
    logic       bt_up;
    logic       bt_dn;
    logic       bt_lf;
    logic       bt_rt;

    typedef struct {
        int         cyc;
        logic [3:0] stb;
        logic [5:0] x;
        logic [5:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    duty_jog_ctrl #(
        .DB_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8),
        .DUTY_INIT(32),
        .DUTY_MAX(63)
    ) dut (
        .sysclk(sysclk),
        .Reset_Sw(Reset_Sw),
        .Bt_Up_Raw(up_raw),
        .Bt_Down_Raw(dn_raw),
        .Bt_Left_Raw(lf_raw),
        .Bt_Right_Raw(rt_raw),
        .Duty_X(duty_x),
        .Duty_Y(duty_y),
        .Bt_Up(bt_up),
        .Bt_Down(bt_dn),
        .Bt_Left(bt_lf),
        .Bt_Right(bt_rt)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] s,
                        input int x, input int y);
        exp_t e;
        e.cyc = c;
        e.stb = s;
        e.x   = 6'(x);
        e.y   = 6'(y);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge sysclk);
                if ({bt_rt, bt_lf, bt_dn, bt_up} != 4'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: cyc %0d stb %b",
                                 cyc, {bt_rt, bt_lf, bt_dn, bt_up});
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("strobe_cycle", cyc, e.cyc);
                        chk("strobe_bits", int'({bt_rt, bt_lf, bt_dn, bt_up}),
                            int'(e.stb));
                        chk("strobe_duty_x", int'(duty_x), int'(e.x));
                        chk("strobe_duty_y", int'(duty_y), int'(e.y));
                    end
                end
            end
            begin
                int t0;
                tick(2);
                Reset_Sw = 1'b0;
                chk("reset_duty_x", int'(duty_x), 32);
                chk("reset_duty_y", int'(duty_y), 32);
                chk("reset_strobes", int'({bt_rt, bt_lf, bt_dn, bt_up}), 0);
                tick(3);

                // single Up press
                t0 = cyc;
                up_raw = 1'b1;
                push(t0 + 7, 4'b0001, 32, 33);
                tick(10);
                up_raw = 1'b0;
                tick(20);

                // Right bounce, never stable for 4 samples
                for (int i = 0; i < 10; i++) begin
                    rt_raw = ~rt_raw;
                    tick(2);
                end
                rt_raw = 1'b0;
                tick(20);
                chk("bounce_duty_x", int'(duty_x), 32);

                // Left auto-repeat for 60 cycles
                t0 = cyc;
                lf_raw = 1'b1;
                push(t0 + 7, 4'b0100, 31, 33);
                for (int k = 0; k < 5; k++)
                    push(t0 + 27 + 8 * k, 4'b0100, 30 - k, 33);
                tick(60);
                lf_raw = 1'b0;
                tick(20);
                chk("repeat_duty_x", int'(duty_x), 26);

                // Up held to saturation: 31 steps from 33
                t0 = cyc;
                up_raw = 1'b1;
                for (int k = 1; k <= 31; k++)
                    push((k == 1) ? t0 + 7 : t0 + 27 + 8 * (k - 2), 4'b0001,
                         26, (33 + k > 63) ? 63 : 33 + k);
                tick(260);
                up_raw = 1'b0;
                tick(20);

                // single Up at the top
                t0 = cyc;
                up_raw = 1'b1;
                push(t0 + 7, 4'b0001, 26, 63);
                tick(10);
                up_raw = 1'b0;
                tick(20);

                // Up and Down together
                t0 = cyc;
                up_raw = 1'b1;
                dn_raw = 1'b1;
                push(t0 + 7, 4'b0011, 26, 63);
                tick(10);
                up_raw = 1'b0;
                dn_raw = 1'b0;
                tick(20);
                chk("opposed_duty_y", int'(duty_y), 63);

                // Down held to 28, then reset while still held
                t0 = cyc;
                dn_raw = 1'b1;
                for (int k = 1; k <= 35; k++)
                    push((k == 1) ? t0 + 7 : t0 + 27 + 8 * (k - 2), 4'b0010,
                         26, 63 - k);
                tick(292);
                Reset_Sw = 1'b1;
                tick(1);
                Reset_Sw = 1'b0;
                chk("midreset_duty_y", int'(duty_y), 32);
                chk("midreset_duty_x", int'(duty_x), 32);
                t0 = cyc;
                push(t0 + 7, 4'b0010, 32, 31);
                tick(10);
                dn_raw = 1'b0;
                tick(20);

                chk("missing_strobes", exp_q.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
